// File: rtl/cadence_meas.sv
// cadence_meas: times the interval between filtered cadence rising edges,
// keeps a 4-sample moving average of the quantised period and flags when
// the rider has stopped pedalling.
module cadence_meas #(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cadence_rise,
    output logic [7:0] cadence_per,
    output logic [7:0] cadence_avg,
    output logic       cadence_vld,
    output logic       not_pedaling
);

    localparam int unsigned TW = 24;
    localparam int unsigned PW = 8;
    localparam int unsigned SW = 10;
    localparam logic [TW-1:0] STALL = FAST_SIM ? TW'(8191) : TW'(24'hFF_FFFF);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_FIRST   = 2'd1,
        ST_RUNNING = 2'd2
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [PW-1:0]   hist_q [4];
    logic [SW-1:0]   sum_q;
    logic [1:0]      wptr_q;
    logic [PW-1:0]   per_q;
    logic [PW-1:0]   avg_q;
    logic            vld_q;
    logic            np_q;

    logic [PW-1:0]   p_d;
    logic [SW-1:0]   sum_d;
    logic            stall_d;
    logic            go_stop_d;

    // The timer reaches STALL on the same edge that the stall is declared,
    // so the stall is detected one count early; a coincident rise still wins.
    always_comb begin
        p_d       = FAST_SIM ? timer_q[12:5] : timer_q[23:16];
        sum_d     = sum_q - SW'(hist_q[wptr_q]) + SW'(p_d);
        stall_d   = (timer_q >= STALL - TW'(1));
        go_stop_d = (state_q != ST_STOPPED) && !cadence_rise && stall_d;
    end

    // Measurement FSM with interval timer, history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOPPED;
            timer_q <= '0;
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            sum_q   <= '0;
            wptr_q  <= '0;
            per_q   <= 8'hFF;
            avg_q   <= 8'hFF;
            vld_q   <= 1'b0;
            np_q    <= 1'b1;
        end else begin
            vld_q <= 1'b0;
            if (go_stop_d) begin
                state_q <= ST_STOPPED;
                timer_q <= '0;
                for (int i = 0; i < 4; i++) hist_q[i] <= '0;
                sum_q   <= '0;
                wptr_q  <= '0;
                per_q   <= 8'hFF;
                avg_q   <= 8'hFF;
                np_q    <= 1'b1;
            end else begin
                case (state_q)
                    ST_STOPPED: begin
                        if (cadence_rise) begin
                            state_q <= ST_FIRST;
                            timer_q <= TW'(1);
                        end else begin
                            timer_q <= '0;
                        end
                    end
                    ST_FIRST: begin
                        if (cadence_rise) begin
                            // First full interval: preload the whole history.
                            for (int i = 0; i < 4; i++) hist_q[i] <= p_d;
                            sum_q   <= {p_d, 2'b00};
                            per_q   <= p_d;
                            avg_q   <= p_d;
                            vld_q   <= 1'b1;
                            np_q    <= 1'b0;
                            state_q <= ST_RUNNING;
                            timer_q <= TW'(1);
                        end else begin
                            timer_q <= (timer_q == STALL) ? STALL : timer_q + TW'(1);
                        end
                    end
                    ST_RUNNING: begin
                        if (cadence_rise) begin
                            hist_q[wptr_q] <= p_d;
                            wptr_q  <= wptr_q + 2'd1;
                            sum_q   <= sum_d;
                            per_q   <= p_d;
                            avg_q   <= sum_d[9:2];
                            vld_q   <= 1'b1;
                            np_q    <= 1'b0;
                            timer_q <= TW'(1);
                        end else begin
                            timer_q <= (timer_q == STALL) ? STALL : timer_q + TW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_STOPPED;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

    assign cadence_per  = per_q;
    assign cadence_avg  = avg_q;
    assign cadence_vld  = vld_q;
    assign not_pedaling = np_q;

endmodule

// File: doc/cadence_meas.md
# cadence_meas

Measures pedal cadence from the one-cycle rising-edge pulses produced by the cadence filter. Times the interval between consecutive edges, keeps a 4-sample moving average and detects when the rider has stopped pedalling. Outputs feed the assist/torque controller, which scales motor assist by cadence and shuts assist off on `not_pedaling`.

## Interface
- `FAST_SIM`, default 1: shortens the stall timeout and the period quantisation window for simulation.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cadence_rise`  in  1  one-cycle pulse, one per filtered cadence rising edge.
- `cadence_per`  out  8  quantised period of the last interval; larger means slower.
- `cadence_avg`  out  8  mean of the last 4 quantised periods.
- `cadence_vld`  out  1  one-cycle pulse when `cadence_per`/`cadence_avg` update.
- `not_pedaling`  out  1  high while no valid cadence is established.

## Operation
- Constants:
  - STALL = 8191 when FAST_SIM, else 2^24−1.
  - Quantiser q(t) = t[12:5] when FAST_SIM, else t[23:16].
- 24-bit interval timer:
  - On `cadence_rise`, loads 1.
  - Otherwise increments by 1 in FIRST/RUNNING, saturating at STALL.
  - Held at 0 in STOPPED.
  - The timer value at a rise therefore equals P, the cycle distance between the two rises.
- FSM states: STOPPED (reset), FIRST, RUNNING.
  - STOPPED: on rise, go to FIRST. No output update, no `cadence_vld`.
  - FIRST: on rise, capture p = q(timer), go to RUNNING, and preload all 4 history entries with p (sum = 4p). If timer == STALL with no rise, return to STOPPED.
  - RUNNING: on rise, capture p = q(timer) and replace the oldest history entry (2-bit write pointer, wraps 3→0). If timer == STALL with no rise, go to STOPPED.
- History sum is 10 bits, updated incrementally as sum − oldest + p. `cadence_avg` = new sum[9:2] (truncating).
- On every capture: `cadence_per` ← p, `cadence_avg` ← new average, `cadence_vld` pulses.
- `not_pedaling` = 1 in STOPPED and FIRST, 0 in RUNNING.
- On entry to STOPPED:
  - `cadence_per` and `cadence_avg` ← 8'hFF.
  - History is cleared.
  - Write pointer ← 0.
- Boundary cases:
  - Rise in the same cycle timer == STALL: the rise wins. Capture p = q(STALL) and stay in, or enter, RUNNING.
  - Rise while in STOPPED never produces `cadence_vld`.
  - Back-to-back rises (P = 1) are legal. p = q(1) = 0.

## Timing
- Reset values:
  - state STOPPED, timer 0.
  - `cadence_per` 8'hFF, `cadence_avg` 8'hFF.
  - `cadence_vld` 0, `not_pedaling` 1.
  - History 0, pointer 0.
- All outputs are registered.
- A rise sampled at edge N updates `cadence_per`, `cadence_avg` and `not_pedaling`, and asserts `cadence_vld`, all visible after edge N (one-cycle latency).
- `cadence_vld` is high for exactly one cycle per capture.
- Stall timing: last rise at edge N, timer == STALL at edge N+STALL−1. With no rise there, `not_pedaling` rises and the outputs become FF after edge N+STALL−1.
- `rst` high at an edge overrides everything, including a coincident `cadence_rise`. All state returns to reset values after that edge, from any state.

## Test plan
- Reset, then idle 20000 cycles with FAST_SIM=1.
  - Required: `not_pedaling`=1, `cadence_per`=`cadence_avg`=FF, no `cadence_vld`.
- Rises every 320 cycles.
  - First rise: no `cadence_vld`.
  - Second rise: `cadence_vld` one cycle later with `cadence_per`=10, `cadence_avg`=10, `not_pedaling`=0.
- Steady at 320-cycle intervals, then one 640-cycle interval.
  - Required: `cadence_per`=20, `cadence_avg`=12 (sum 50).
  - Three more 640-cycle intervals: `cadence_avg` steps 15, 17, 20.
- In RUNNING, stop rises.
  - Required: exactly STALL−1 edges after the last rise, `not_pedaling`=1 and both outputs FF.
  - Next two rises: re-acquire through FIRST to RUNNING with history preloaded.
- Rise coincident with timer == STALL in FIRST.
  - Required: `cadence_per`=255, state RUNNING, `cadence_vld` pulses.
- Assert `rst` mid-RUNNING together with a `cadence_rise`.
  - Required: no `cadence_vld`; all outputs at reset values the next cycle.
